// File: rtl/uart_rx_deframer.sv
// 8N1 asynchronous serial receiver with a VALID/READY holding register and
// framing/overrun pulses. Define UART_RX_PARITY_EN to add an even-parity bit and PARITY_ERR.
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       READY,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
`ifdef UART_RX_PARITY_EN
    output logic       PARITY_ERR,
`endif
    output logic       BUSY
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    logic                   rx_s;
    logic                   fall_s;

    state_e          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            busy_q, busy_d;
    logic            deliver_s;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign fall_s = rx_prev_q & ~rx_s;

    // Even parity: data bits plus parity bit must hold an even number of ones.
    function automatic logic parity_bad(input logic [7:0] d, input logic p);
        parity_bad = ^{d, p};
    endfunction

    // RX synchroniser chain and the delayed copy used for falling-edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q    <= {SYNC_STAGES{1'b1}};
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], RX};
            rx_prev_q <= rx_s;
        end
    end

    // Frame FSM: next state, baud/bit counters and shift register.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        deliver_s = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d    = BAUD_ZERO;
                bit_idx_d = 3'd0;
                if (fall_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_q == BAUD_HALF) begin
                    baud_d    = BAUD_ZERO;
                    bit_idx_d = 3'd0;
                    if (rx_s == 1'b0) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d             = BAUD_ZERO;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = BAUD_ZERO;
                    par_d   = rx_s;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
`endif
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = BAUD_ZERO;
                    if (rx_s == 1'b1) begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (parity_bad(shift_q, par_q)) begin
                            perr_d = 1'b1;
                        end else begin
                            deliver_s = 1'b1;
                        end
`else
                        deliver_s = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_WAIT_HIGH: begin
                // A held-low break must release before another start can arm.
                if (rx_s == 1'b1) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_HIGH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Holding register: load on delivery unless still full and not being drained.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        busy_d  = (state_d != S_IDLE);
        if (deliver_s) begin
            if (!valid_q || READY) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && READY) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            baud_q    <= BAUD_ZERO;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign DATA      = data_q;
    assign VALID     = valid_q;
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = ovr_q;
    assign BUSY      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign PARITY_ERR = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed + randomized bench for uart_rx_deframer (CLKS_PER_BIT=8, SYNC_STAGES=2).
// A frame-level model predicts delivered bytes and error pulses.
module tb_uart_rx_deframer;

    localparam int CPB  = 8;
    localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int DELIV = SYNC + 1 + CPB / 2 + (NBITS - 1) * CPB;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic       RX    = 1'b1;
    logic       READY = 1'b0;
    logic [7:0] DATA;
    logic       VALID;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       BUSY;
`ifdef UART_RX_PARITY_EN
    logic       PARITY_ERR;
    int         n_perr = 0;
    int         exp_perr = 0;
`endif

    int checks = 0;
    int errors = 0;
    int n_ferr = 0;
    int n_ovr  = 0;
    int exp_ferr = 0;
    int lat;
    logic [7:0] acc_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] b1, b2, b3, b4, rb;
    logic       stop_ok, pflip;
    int         gap;

    uart_rx_deframer #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX        (RX),
        .DATA      (DATA),
        .VALID     (VALID),
        .READY     (READY),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN),
`ifdef UART_RX_PARITY_EN
        .PARITY_ERR(PARITY_ERR),
`endif
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Serial line driver: start, 8 data bits LSB first, optional parity, stop.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic flip);
        RX = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (CPB) tick();
        end
`ifdef UART_RX_PARITY_EN
        RX = (^b) ^ flip;
        repeat (CPB) tick();
`else
        if (flip) RX = 1'b1;
`endif
        RX = stop_bit;
        repeat (CPB) tick();
    endtask

    task automatic compare_queues(input string tag);
        chk({tag, "_count"}, acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < acc_q.size()) chk({tag, "_byte"}, acc_q[i], exp_q[i]);
        end
        acc_q.delete();
        exp_q.delete();
    endtask

    // Monitor: handshakes and pulses sampled mid-cycle.
    always @(negedge CLK) begin
        if (VALID === 1'b1 && READY === 1'b1) acc_q.push_back(DATA);
        if (FRAME_ERR === 1'b1) n_ferr++;
        if (OVERRUN === 1'b1) n_ovr++;
        if (FRAME_ERR === 1'b1 || OVERRUN === 1'b1) chk("ferr_ovr_exclusive", FRAME_ERR & OVERRUN, 0);
`ifdef UART_RX_PARITY_EN
        if (PARITY_ERR === 1'b1) n_perr++;
`endif
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        chk("rst_data", DATA, 0);
        chk("rst_valid", VALID, 0);
        chk("rst_ferr", FRAME_ERR, 0);
        chk("rst_ovr", OVERRUN, 0);
        chk("rst_busy", BUSY, 0);
        RST = 1'b0;
        repeat (2) tick();

        // Single frame 0xA5 with latency measurement
        READY = 1'b1;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                lat = 0;
                while (VALID !== 1'b1 && lat < 400) begin
                    tick();
                    lat++;
                end
            end
        join
        chk("latency_in_range", (lat >= DELIV - 1 && lat <= DELIV + 1), 1);
        chk("valid_one_cycle", VALID, 0);
        repeat (CPB) tick();
        chk("a5_busy_low", BUSY, 0);
        compare_queues("a5");
        chk("a5_no_ferr", n_ferr, 0);
        chk("a5_no_ovr", n_ovr, 0);

        // False start: two-cycle glitch
        RX = 1'b0;
        repeat (2) tick();
        RX = 1'b1;
        tick();
        chk("glitch_busy_high", BUSY, 1);
        repeat (10) tick();
        chk("glitch_busy_low", BUSY, 0);
        chk("glitch_no_ferr", n_ferr, 0);
        chk("glitch_no_valid", VALID, 0);
        compare_queues("glitch");

        // Framing error followed by a held-low break
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40) tick();
        exp_ferr++;
        chk("break_busy", BUSY, 1);
        chk("break_ferr_count", n_ferr, exp_ferr);
        chk("break_no_valid", VALID, 0);
        RX = 1'b1;
        repeat (4) tick();
        chk("break_release_idle", BUSY, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (4) tick();
        compare_queues("after_break");

        // Overrun with READY low across two back-to-back frames
        READY = 1'b0;
        b1 = 8'($urandom_range(1, 255));
        b2 = 8'($urandom_range(1, 255));
        send_frame(b1, 1'b1, 1'b0);
        send_frame(b2, 1'b1, 1'b0);
        repeat (4) tick();
        chk("ovr_valid", VALID, 1);
        chk("ovr_data_held", DATA, b1);
        chk("ovr_count", n_ovr, 1);
        READY = 1'b1;
        tick();
        READY = 1'b0;
        chk("ovr_drained", VALID, 0);
        chk("ovr_data_kept", DATA, b1);
        exp_q.push_back(b1);
        compare_queues("ovr");

        // READY asserted exactly in the delivery cycle of the second byte
        b3 = 8'($urandom_range(1, 255));
        b4 = 8'($urandom_range(1, 255));
        send_frame(b3, 1'b1, 1'b0);
        repeat (2) tick();
        chk("rdy_first_valid", VALID, 1);
        chk("rdy_first_data", DATA, b3);
        fork
            send_frame(b4, 1'b1, 1'b0);
            begin
                repeat (DELIV - 1) tick();
                READY = 1'b1;
                tick();
                READY = 1'b0;
            end
        join
        repeat (2) tick();
        chk("rdy_swap_valid", VALID, 1);
        chk("rdy_swap_data", DATA, b4);
        chk("rdy_no_ovr", n_ovr, 1);
        exp_q.push_back(b3);
        compare_queues("rdy_swap");

        // Reset in the middle of data bit 4 of 0xFF
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                repeat (CPB * 5 + CPB / 2) tick();
                RST = 1'b1;
                #1;
                chk("midrst_data", DATA, 0);
                chk("midrst_valid", VALID, 0);
                chk("midrst_busy", BUSY, 0);
                chk("midrst_ferr", FRAME_ERR, 0);
                chk("midrst_ovr", OVERRUN, 0);
                repeat (3) tick();
                RST = 1'b0;
            end
        join
        repeat (CPB) tick();
        chk("midrst_idle", BUSY, 0);
        chk("midrst_no_valid", VALID, 0);
        READY = 1'b1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (4) tick();
        compare_queues("post_rst");
`ifdef UART_RX_PARITY_EN
        send_frame(8'h5A, 1'b1, 1'b1);
        exp_perr++;
        repeat (4) tick();
        chk("parity_err_count", n_perr, exp_perr);
        chk("parity_no_valid", VALID, 0);
`endif

        // Randomized frames against the frame-level model
        for (int k = 0; k < 12; k++) begin
            rb      = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            pflip   = ($urandom_range(0, 3) == 0);
`else
            pflip   = 1'b0;
`endif
            send_frame(rb, stop_ok, pflip);
            if (!stop_ok) begin
                exp_ferr++;
                RX  = 1'b1;
                gap = 4 + $urandom_range(0, CPB);
            end else begin
                gap = $urandom_range(0, 1) * $urandom_range(0, 2 * CPB);
`ifdef UART_RX_PARITY_EN
                if (pflip) exp_perr++;
                else exp_q.push_back(rb);
`else
                exp_q.push_back(rb);
`endif
            end
            repeat (gap) tick();
        end
        RX = 1'b1;
        repeat (2 * CPB) tick();
        compare_queues("random");
        chk("random_ferr_count", n_ferr, exp_ferr);
        chk("random_ovr_count", n_ovr, 1);
        chk("random_busy_end", BUSY, 0);
`ifdef UART_RX_PARITY_EN
        chk("random_perr_count", n_perr, exp_perr);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
